loba_pp_accum: RTL and testbench

- Downstream consumer of the leading-one split stage (one split per operand).
- Takes the high and low K-bit segments plus leading-one positions of operands A and B and forms the approximate product.
- Product form: (Ah·2^sah + Al·2^sal)·(Bh·2^sbh + Bl·2^sbl). The four partial products are computed on one time-multiplexed K×K multiplier and summed in an accumulator.
- valid/ready handshake on input and output; one product in flight.

---
 rtl/loba_pkg.sv | 16 +
 rtl/loba_term.sv | 45 ++++
 rtl/loba_pp_accum.sv | 156 +++++++++++++++
 tb/tb_loba_pp_accum.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/loba_pkg.sv
// Shared types and helpers for the leading-one product accumulator.
// LOBA_TRUNC_COMP_EN selects midpoint compensation inside loba_term.
package loba_pkg;

  localparam int N_DEF = 16;
  localparam int K_DEF = 4;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
  typedef enum logic [1:0] {HH, HL, LH, LL} term_t;

  // Shift that restores a K-bit segment whose leading one sits at position k.
  function automatic logic [7:0] seg_shift(input logic [7:0] k, input logic [7:0] k_seg);
    return (k >= k_seg - 8'd1) ? k - (k_seg - 8'd1) : 8'd0;
  endfunction

endpackage

// File: rtl/loba_term.sv
// One shifted partial product of two segments (combinational).
// LOBA_TRUNC_COMP_EN widens each segment to x<<1|1 with shift s-1 when s>0.
module loba_term
  import loba_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int K  = K_DEF,
  parameter int KW = $clog2(N)
) (
  input  logic [K-1:0]   i_xa,
  input  logic [K-1:0]   i_xb,
  input  logic [KW-1:0]  i_sa,
  input  logic [KW-1:0]  i_sb,
  output logic [2*N+1:0] o_term
);

`ifdef LOBA_TRUNC_COMP_EN
  localparam int MW = K + 1;
  logic [MW-1:0] w_va, w_vb;
  logic [KW-1:0] w_ea, w_eb;

  // The dropped bits are replaced by their midpoint, so the restored shift is one less.
  assign w_va = (i_sa != '0) ? {i_xa, 1'b1} : {1'b0, i_xa};
  assign w_vb = (i_sb != '0) ? {i_xb, 1'b1} : {1'b0, i_xb};
  assign w_ea = (i_sa != '0) ? i_sa - KW'(1) : '0;
  assign w_eb = (i_sb != '0) ? i_sb - KW'(1) : '0;
`else
  localparam int MW = K;
  logic [MW-1:0] w_va, w_vb;
  logic [KW-1:0] w_ea, w_eb;

  assign w_va = i_xa;
  assign w_vb = i_xb;
  assign w_ea = i_sa;
  assign w_eb = i_sb;
`endif

  logic [2*MW-1:0] w_prod;
  logic [KW:0]     w_sh;

  assign w_prod = {{MW{1'b0}}, w_va} * {{MW{1'b0}}, w_vb};
  assign w_sh   = {1'b0, w_ea} + {1'b0, w_eb};
  assign o_term = (2*N+2)'(w_prod) << w_sh;

endmodule

// File: rtl/loba_pp_accum.sv
// Approximate product of two leading-one split operands, four terms on one multiplier.
// LOBA_TRUNC_COMP_EN enables midpoint compensation of truncated segment bits.
module loba_pp_accum
  import loba_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int K  = K_DEF,
  parameter int KW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [K-1:0]    a_xh,
  input  logic [K-1:0]    a_xl,
  input  logic [KW-1:0]   a_kh,
  input  logic [KW-1:0]   a_kl,
  input  logic            a_lv,
  input  logic [K-1:0]    b_xh,
  input  logic [K-1:0]    b_xl,
  input  logic [KW-1:0]   b_kh,
  input  logic [KW-1:0]   b_kl,
  input  logic            b_lv,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*N-1:0]  p
);

  state_t          r_state, w_state_n;
  term_t           r_idx, w_idx_n;
  logic            w_has_next;
  logic            r_live;
  logic [2*N+1:0]  r_acc;

  logic [K-1:0]    r_a_xh, r_a_xl, r_b_xh, r_b_xl;
  logic [KW-1:0]   r_a_kh, r_a_kl, r_b_kh, r_b_kl;
  logic            r_a_lv, r_b_lv;

  logic [KW-1:0]   w_sah, w_sal, w_sbh, w_sbl;
  logic [K-1:0]    w_xa, w_xb;
  logic [KW-1:0]   w_sa, w_sb;
  logic [2*N+1:0]  w_term;
  logic            w_accept;

  assign w_sah = KW'(seg_shift(8'(r_a_kh), 8'(K)));
  assign w_sal = KW'(seg_shift(8'(r_a_kl), 8'(K)));
  assign w_sbh = KW'(seg_shift(8'(r_b_kh), 8'(K)));
  assign w_sbl = KW'(seg_shift(8'(r_b_kl), 8'(K)));

  always_comb begin
    w_xa = r_a_xh;
    w_xb = r_b_xh;
    w_sa = w_sah;
    w_sb = w_sbh;
    case (r_idx)
      HH: begin w_xa = r_a_xh; w_xb = r_b_xh; w_sa = w_sah; w_sb = w_sbh; end
      HL: begin w_xa = r_a_xh; w_xb = r_b_xl; w_sa = w_sah; w_sb = w_sbl; end
      LH: begin w_xa = r_a_xl; w_xb = r_b_xh; w_sa = w_sal; w_sb = w_sbh; end
      LL: begin w_xa = r_a_xl; w_xb = r_b_xl; w_sa = w_sal; w_sb = w_sbl; end
      default: ;
    endcase
  end

  loba_term #(.N(N), .K(K), .KW(KW)) u_term (
    .i_xa   (w_xa),
    .i_xb   (w_xb),
    .i_sa   (w_sa),
    .i_sb   (w_sb),
    .o_term (w_term)
  );

  // Skip straight to the next enabled term so disabled terms cost no cycle.
  always_comb begin
    w_has_next = 1'b0;
    w_idx_n    = r_idx;
    case (r_idx)
      HH: begin
        if (r_b_lv) begin
          w_has_next = 1'b1;
          w_idx_n    = HL;
        end else if (r_a_lv) begin
          w_has_next = 1'b1;
          w_idx_n    = LH;
        end
      end
      HL: begin
        if (r_a_lv) begin
          w_has_next = 1'b1;
          w_idx_n    = LH;
        end
      end
      LH: begin
        if (r_b_lv) begin
          w_has_next = 1'b1;
          w_idx_n    = LL;
        end
      end
      default: ;
    endcase
  end

  assign in_ready  = r_live && (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign w_accept  = in_valid && in_ready;
  assign p         = (r_acc[2*N+1:2*N] != 2'b00) ? {(2*N){1'b1}} : r_acc[2*N-1:0];

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_n = MUL;
      MUL:     if (!w_has_next) w_state_n = DONE;
      DONE:    if (out_ready) w_state_n = IDLE;
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= HH;
      r_acc   <= '0;
      r_live  <= 1'b0;
      r_a_xh  <= '0;
      r_a_xl  <= '0;
      r_a_kh  <= '0;
      r_a_kl  <= '0;
      r_a_lv  <= 1'b0;
      r_b_xh  <= '0;
      r_b_xl  <= '0;
      r_b_kh  <= '0;
      r_b_kl  <= '0;
      r_b_lv  <= 1'b0;
    end else begin
      r_live  <= 1'b1;
      r_state <= w_state_n;
      if (r_state == IDLE && w_accept) begin
        r_acc  <= '0;
        r_idx  <= HH;
        r_a_xh <= a_xh;
        r_a_xl <= a_xl;
        r_a_kh <= a_kh;
        r_a_kl <= a_kl;
        r_a_lv <= a_lv;
        r_b_xh <= b_xh;
        r_b_xl <= b_xl;
        r_b_kh <= b_kh;
        r_b_kl <= b_kl;
        r_b_lv <= b_lv;
      end else if (r_state == MUL) begin
        r_acc <= r_acc + w_term;
        if (w_has_next) r_idx <= w_idx_n;
      end
    end
  end

endmodule

// File: tb/tb_loba_pp_accum.sv
// Directed bench for loba_pp_accum against an operand-level product model.
// Define LOBA_TRUNC_COMP_EN for both bench and RTL to exercise compensation.
module tb_loba_pp_accum;

  typedef struct packed {
    logic [3:0] xh;
    logic [3:0] xl;
    logic [3:0] kh;
    logic [3:0] kl;
    logic       lv;
  } seg_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] p;
  seg_t        sa = '0;
  seg_t        sb = '0;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  loba_pp_accum #(.N(16), .K(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_xh      (sa.xh),
    .a_xl      (sa.xl),
    .a_kh      (sa.kh),
    .a_kl      (sa.kl),
    .a_lv      (sa.lv),
    .b_xh      (sb.xh),
    .b_xl      (sb.xl),
    .b_kh      (sb.kh),
    .b_kl      (sb.kl),
    .b_lv      (sb.lv),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Value a segment stands for once its truncation shift is restored.
  function automatic longint unsigned seg_val(input logic [3:0] x, input logic [3:0] k);
    int s;
    s = (k >= 3) ? int'(k) - 3 : 0;
`ifdef LOBA_TRUNC_COMP_EN
    if (s > 0) return longint'((2 * int'(x) + 1)) << (s - 1);
`endif
    return longint'(x) << s;
  endfunction

  // Product of the two reconstructed operands, saturated to 32 bits.
  function automatic logic [31:0] model(input seg_t a, input seg_t b);
    longint unsigned va, vb, prod;
    va = seg_val(a.xh, a.kh) + (a.lv ? seg_val(a.xl, a.kl) : 64'd0);
    vb = seg_val(b.xh, b.kh) + (b.lv ? seg_val(b.xl, b.kl) : 64'd0);
    prod = va * vb;
    return (prod >= 64'h1_0000_0000) ? 32'hFFFF_FFFF : prod[31:0];
  endfunction

  function automatic int n_terms(input seg_t a, input seg_t b);
    return 1 + int'(a.lv) + int'(b.lv) + int'(a.lv & b.lv);
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_out_valid: got p=0x%0h with no product pending", p);
      end else begin
        chk("p", {32'd0, p}, {32'd0, exp_q[0]});
      end
    end
  end

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("in_ready_timeout", 64'd0, 64'd1);
  endtask

  // One full transaction with out_ready held low for hold cycles once out_valid rises.
  task automatic run(input seg_t a, input seg_t b, input int hold);
    bit ok;
    int lat;
    wait_ready(ok);
    if (!ok) return;
    sa = a;
    sb = b;
    in_valid = 1'b1;
    exp_q.push_back(model(a, b));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    sa = '0;
    sb = '0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", 64'(lat), 64'(n_terms(a, b)));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_out_valid", {63'd0, out_valid}, 64'd1);
      chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
      in_valid = (i == 0);
      sa = '{xh: 4'hF, xl: 4'hF, kh: 4'd15, kl: 4'd15, lv: 1'b1};
      sb = sa;
    end
    @(negedge clk);
    in_valid = 1'b0;
    sa = '0;
    sb = '0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    void'(exp_q.pop_front());
    chk("out_valid_drop", {63'd0, out_valid}, 64'd0);
    chk("in_ready_back", {63'd0, in_ready}, 64'd1);
  endtask

  seg_t a1, b1, a2, b2, a3, a4, b4, c1;

  initial begin
    bit ok;
    a1 = '{xh: 4'hF, xl: 4'h0, kh: 4'd15, kl: 4'd0,  lv: 1'b0};
    b1 = '{xh: 4'h8, xl: 4'h0, kh: 4'd12, kl: 4'd0,  lv: 1'b0};
    a2 = '{xh: 4'hF, xl: 4'hF, kh: 4'd15, kl: 4'd7,  lv: 1'b1};
    b2 = '{xh: 4'h8, xl: 4'h0, kh: 4'd8,  kl: 4'd0,  lv: 1'b0};
    a3 = '{xh: 4'hF, xl: 4'hF, kh: 4'd15, kl: 4'd11, lv: 1'b1};
    // lv=0 with junk low fields: they must not reach the sum
    a4 = '{xh: 4'hF, xl: 4'hF, kh: 4'd7,  kl: 4'd14, lv: 1'b0};
    b4 = '{xh: 4'h8, xl: 4'h8, kh: 4'd15, kl: 4'd3,  lv: 1'b1};
    c1 = '{xh: 4'hF, xl: 4'hF, kh: 4'd15, kl: 4'd15, lv: 1'b1};

`ifdef LOBA_TRUNC_COMP_EN
    chk("model_comp", {32'd0, model(a1, '{xh: 4'h8, xl: 4'h0, kh: 4'd11, kl: 4'd0, lv: 1'b0})},
        64'h083C_0000);
`else
    chk("model_single", {32'd0, model(a1, b1)}, 64'h0F00_0000);
    chk("model_two", {32'd0, model(a2, b2)}, 64'h00F0_F000);
    chk("model_four", {32'd0, model(a3, a3)}, 64'hFE01_0000);
    chk("model_hl_only", {32'd0, model(a4, b4)}, 64'h0078_0780);
`endif
    chk("model_sat", {32'd0, model(c1, c1)}, 64'hFFFF_FFFF);

    #2;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_p", {32'd0, p}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("post_rst_in_ready_low", {63'd0, in_ready}, 64'd0);
    @(posedge clk);
    #1;
    chk("post_rst_in_ready_high", {63'd0, in_ready}, 64'd1);

    run(a1, b1, 0);
    run(a2, b2, 0);
    run(a3, a3, 0);
    run(a4, b4, 0);
    run(c1, c1, 0);
    run(a1, b1, 3);
`ifdef LOBA_TRUNC_COMP_EN
    run(a1, '{xh: 4'h8, xl: 4'h0, kh: 4'd11, kl: 4'd0, lv: 1'b0}, 0);
`endif

    // reset during the second MUL cycle of a four-term product
    wait_ready(ok);
    sa = a3;
    sb = a3;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midop_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midop_in_ready", {63'd0, in_ready}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("midop_rel_in_ready_low", {63'd0, in_ready}, 64'd0);
    chk("midop_rel_out_valid", {63'd0, out_valid}, 64'd0);
    @(posedge clk);
    #1;
    chk("midop_rel_in_ready_high", {63'd0, in_ready}, 64'd1);
    run(a1, b1, 0);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
